// File: rtl/mem_model_avm_axi_pkg.sv
// Shared types and constants for the Avalon-MM to AXI bridge.
// Holds the FSM encoding, AXI burst/response codes and a burst-length helper.
package mem_model_avm_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Avalon burstcount of 0 is treated as a single beat.
    function automatic logic [7:0] burst_len(input logic [8:0] burstcount);
        logic [8:0] len_s;
        if (burstcount == 9'd0) begin
            len_s = 9'd0;
        end else begin
            len_s = burstcount - 9'd1;
        end
        return len_s[7:0];
    endfunction

endpackage

// File: rtl/mem_model_avm_axi.sv
// Avalon-MM burst subordinate to AXI manager bridge, one transaction in flight.
// Write bursts become AW+W+B, read bursts become AR+R; bad responses latch resp_err.
module mem_model_avm_axi
    import mem_model_avm_axi_pkg::*;
#(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int WR_ID      = 0,
    parameter int RD_ID      = 0
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [ADDRWIDTH-1:0]     av_address,
    input  logic [8:0]               av_burstcount,
    input  logic                     av_write,
    input  logic [DATAWIDTH-1:0]     av_writedata,
    input  logic [DATAWIDTH/8-1:0]   av_byteenable,
    input  logic                     av_read,
    output logic                     av_waitrequest,
    output logic [DATAWIDTH-1:0]     av_readdata,
    output logic                     av_readdatavalid,
    output logic                     resp_err,
    output logic [ADDRWIDTH-1:0]     awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [ID_W_WIDTH-1:0]    awid,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [DATAWIDTH-1:0]     wdata,
    output logic [DATAWIDTH/8-1:0]   wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    input  logic [ID_W_WIDTH-1:0]    bid,
    input  logic [1:0]               bresp,
    output logic                     bready,
    output logic [ADDRWIDTH-1:0]     araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [ID_R_WIDTH-1:0]    arid,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATAWIDTH-1:0]     rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    input  logic [ID_R_WIDTH-1:0]    rid,
    input  logic [1:0]               rresp,
    output logic                     rready
);

    localparam logic [2:0]            AXSIZE  = 3'($clog2(DATAWIDTH/8));
    localparam logic [ID_W_WIDTH-1:0] AWID_C  = ID_W_WIDTH'(WR_ID);
    localparam logic [ID_R_WIDTH-1:0] ARID_C  = ID_R_WIDTH'(RD_ID);

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   unused_s;

    assign unused_s = ^{bid, rid};

    // State, latches, beat counter and sticky error.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (av_write) begin
                    addr_d  = av_address;
                    len_d   = burst_len(av_burstcount);
                    state_d = ST_WR_ADDR;
                end else if (av_read) begin
                    addr_d  = av_address;
                    len_d   = burst_len(av_burstcount);
                    state_d = ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                if (awready) begin
                    cnt_d   = len_q;
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_DATA: begin
                if (av_write && wready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    err_d   = err_q | (bresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (arready) begin
                    cnt_d   = len_q;
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (rvalid) begin
                    // A missing or early rlast ends the burst: the beat count is no longer trustworthy.
                    err_d = err_q | (rresp != AXI_RESP_OKAY);
                    if (cnt_q == 8'd0) begin
                        err_d   = err_d | ~rlast;
                        state_d = ST_IDLE;
                    end else if (rlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state handshake outputs.
    always_comb begin
        awvalid          = 1'b0;
        wvalid           = 1'b0;
        wlast            = 1'b0;
        bready           = 1'b0;
        arvalid          = 1'b0;
        rready           = 1'b0;
        av_waitrequest   = 1'b1;
        av_readdatavalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                av_waitrequest = 1'b1;
            end
            ST_WR_ADDR: begin
                awvalid = 1'b1;
            end
            ST_WR_DATA: begin
                wvalid         = av_write;
                wlast          = (cnt_q == 8'd0);
                av_waitrequest = ~wready;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
            end
            ST_RD_ADDR: begin
                arvalid        = 1'b1;
                av_waitrequest = ~arready;
            end
            ST_RD_DATA: begin
                rready           = 1'b1;
                av_readdatavalid = rvalid;
            end
            default: begin
                av_waitrequest = 1'b1;
            end
        endcase
    end

    assign awaddr      = addr_q;
    assign awlen       = len_q;
    assign awsize      = AXSIZE;
    assign awburst     = AXI_BURST_INCR;
    assign awid        = AWID_C;
    assign araddr      = addr_q;
    assign arlen       = len_q;
    assign arsize      = AXSIZE;
    assign arburst     = AXI_BURST_INCR;
    assign arid        = ARID_C;
    assign wdata       = av_writedata;
    assign wstrb       = av_byteenable;
    assign av_readdata = rdata;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_mem_model_avm_axi.sv
// Directed bench for mem_model_avm_axi with a small AXI memory subordinate model.
module tb_mem_model_avm_axi;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] av_address;
    logic [8:0]  av_burstcount;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_read;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic        resp_err;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rready;

    always #5 clk = ~clk;

    mem_model_avm_axi dut (
        .clk(clk), .nreset(nreset),
        .av_address(av_address), .av_burstcount(av_burstcount),
        .av_write(av_write), .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_read(av_read), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .resp_err(resp_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rid(rid), .rresp(rresp), .rready(rready)
    );

    // ---------------- AXI subordinate model ----------------
    logic [31:0] mem [0:1023];
    logic [9:0]  w_idx, r_idx;
    logic        wready_q, bvalid_q, rbusy_q;
    int          wbeat, rcnt, rlen_i;
    int          aw_cnt, ar_cnt, b_cnt, w_total, wlast_total, wlast_at;
    logic [7:0]  aw_len_seen, ar_len_seen;
    logic [2:0]  aw_size_seen;
    logic [1:0]  aw_burst_seen;
    bit          wtog;
    logic [1:0]  bresp_inj;
    int          early_rlast;
    bit          mirror_en;

    assign awready = 1'b1;
    assign arready = 1'b1;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_inj;
    assign bid     = 4'd0;
    assign rvalid  = rbusy_q;
    assign rdata   = mem[r_idx];
    assign rlast   = rbusy_q && ((rcnt == rlen_i) || (rcnt == early_rlast));
    assign rid     = 4'd0;
    assign rresp   = 2'b00;

    always @(posedge clk) begin
        if (wvalid && wready) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wready_q <= 1'b1; bvalid_q <= 1'b0; rbusy_q <= 1'b0;
            w_idx <= 10'd0; r_idx <= 10'd0; wbeat <= 0; rcnt <= 0; rlen_i <= 0;
        end else begin
            wready_q <= wtog ? ~wready_q : 1'b1;
            if (awvalid && awready) begin
                aw_cnt <= aw_cnt + 1; w_idx <= awaddr[11:2]; wbeat <= 0;
                aw_len_seen <= awlen; aw_size_seen <= awsize; aw_burst_seen <= awburst;
            end
            if (wvalid && wready) begin
                w_idx <= w_idx + 10'd1; wbeat <= wbeat + 1; w_total <= w_total + 1;
                if (wlast) begin
                    wlast_total <= wlast_total + 1; wlast_at <= wbeat; bvalid_q <= 1'b1;
                end
            end
            if (bvalid && bready) begin
                bvalid_q <= 1'b0; b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                ar_cnt <= ar_cnt + 1; r_idx <= araddr[11:2]; rcnt <= 0;
                rlen_i <= int'(arlen); ar_len_seen <= arlen; rbusy_q <= 1'b1;
            end
            if (rvalid && rready) begin
                r_idx <= r_idx + 10'd1;
                if (rlast) rbusy_q <= 1'b0;
                else rcnt <= rcnt + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] rd_data [0:15];
    int          rd_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mirror_en && wvalid) check("wait_mirror", {31'd0, av_waitrequest}, {31'd0, !wready});
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!av_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic avm_write(input logic [31:0] addr, input int n, input logic [31:0] base,
                             input int abort_at);
        bit ok;
        int b0;
        b0 = b_cnt;
        av_address = addr; av_burstcount = n[8:0]; av_byteenable = 4'hF; av_write = 1'b1;
        for (int i = 0; i < n; i++) begin
            av_writedata = base + i;
            if (i == abort_at) return;
            wait_ready(ok);
            check("wr_beat_accept", {31'd0, ok}, 32'd1);
            @(posedge clk); #1;
        end
        av_write = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (b_cnt != b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wr_bresp_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic collect_reads();
        rd_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (av_readdatavalid && rd_n < 16) begin
                rd_data[rd_n] = av_readdata;
                rd_n++;
            end
        end
    endtask

    task automatic avm_read(input logic [31:0] addr, input int n);
        bit ok;
        av_address = addr; av_burstcount = n[8:0]; av_read = 1'b1;
        wait_ready(ok);
        check("rd_cmd_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        av_read = 1'b0;
        collect_reads();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int a0, r0, b0;
        aw_cnt = 0; ar_cnt = 0; b_cnt = 0; w_total = 0; wlast_total = 0; wlast_at = -1;
        wtog = 1'b0; bresp_inj = 2'b00; early_rlast = -1; mirror_en = 1'b0;
        nreset = 1'b0; av_address = 32'd0; av_burstcount = 9'd0; av_write = 1'b0;
        av_writedata = 32'd0; av_byteenable = 4'h0; av_read = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", {31'd0, av_waitrequest}, 32'd1);
        check("rst_valids", {28'd0, awvalid, wvalid, arvalid, av_readdatavalid}, 32'd0);
        check("rst_readies", {30'd0, bready, rready}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        nreset = 1'b1;
        @(posedge clk); #1;

        // 1: single write then read-back
        avm_write(32'h100, 1, 32'hDEADBEEF, -1);
        check("t1_awlen", {24'd0, aw_len_seen}, 32'd0);
        check("t1_awsize", {29'd0, aw_size_seen}, 32'd2);
        check("t1_awburst", {30'd0, aw_burst_seen}, 32'd1);
        check("t1_wlast_beat", wlast_at, 32'd0);
        check("t1_bready_seen", b_cnt, 32'd1);
        avm_read(32'h100, 1);
        check("t1_rd_n", rd_n, 32'd1);
        check("t1_rd_data", rd_data[0], 32'hDEADBEEF);

        // 2: 8-beat write with wready toggling
        a0 = w_total; b0 = wlast_total;
        wtog = 1'b1; mirror_en = 1'b1;
        avm_write(32'h200, 8, 32'd0, -1);
        wtog = 1'b0; mirror_en = 1'b0;
        check("t2_awlen", {24'd0, aw_len_seen}, 32'd7);
        check("t2_w_beats", w_total - a0, 32'd8);
        check("t2_wlast_count", wlast_total - b0, 32'd1);
        check("t2_wlast_beat", wlast_at, 32'd7);

        // 3: 8-beat read-back
        avm_read(32'h200, 8);
        check("t3_arlen", {24'd0, ar_len_seen}, 32'd7);
        check("t3_rd_n", rd_n, 32'd8);
        for (int i = 0; i < 8; i++) check("t3_rd_data", rd_data[i], i);
        check("t3_resp_err", {31'd0, resp_err}, 32'd0);

        // 4: write and read requested together -> write first
        a0 = aw_cnt; r0 = ar_cnt; b0 = b_cnt;
        av_address = 32'h300; av_burstcount = 9'd1; av_writedata = 32'hA5A5A5A5;
        av_byteenable = 4'hF; av_write = 1'b1; av_read = 1'b1;
        wait_ready(ok);
        check("t4_wr_accept", {31'd0, ok}, 32'd1);
        check("t4_aw_first", aw_cnt - a0, 32'd1);
        check("t4_no_ar_yet", ar_cnt - r0, 32'd0);
        @(posedge clk); #1;
        av_write = 1'b0;
        wait_ready(ok);
        check("t4_rd_accept", {31'd0, ok}, 32'd1);
        check("t4_b_before_rd", b_cnt - b0, 32'd1);
        @(posedge clk); #1;
        av_read = 1'b0;
        collect_reads();
        check("t4_rd_n", rd_n, 32'd1);
        check("t4_rd_data", rd_data[0], 32'hA5A5A5A5);

        // 5b: early rlast on beat 3 of 8
        early_rlast = 2;
        avm_read(32'h200, 8);
        early_rlast = -1;
        check("t5_early_beats", rd_n, 32'd3);
        check("t5_rlast_err", {31'd0, resp_err}, 32'd1);
        avm_read(32'h100, 1);
        check("t5_idle_again", rd_data[0], 32'hDEADBEEF);

        // 6: reset during beat 4 of an 8-beat write
        avm_write(32'h400, 8, 32'h10, 3);
        nreset = 1'b0;
        #1;
        check("t6_valids_low", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        check("t6_waitrequest", {31'd0, av_waitrequest}, 32'd1);
        check("t6_resp_err_clr", {31'd0, resp_err}, 32'd0);
        av_write = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        avm_write(32'h400, 8, 32'h20, -1);
        avm_read(32'h400, 8);
        check("t6_rd_n", rd_n, 32'd8);
        for (int i = 0; i < 8; i++) check("t6_rd_data", rd_data[i], 32'h20 + i);

        // 5a: SLVERR on write response, sticky afterwards
        check("t5_err_before", {31'd0, resp_err}, 32'd0);
        bresp_inj = 2'b10;
        avm_write(32'h500, 1, 32'h55, -1);
        bresp_inj = 2'b00;
        check("t5_bresp_err", {31'd0, resp_err}, 32'd1);
        avm_write(32'h504, 1, 32'h66, -1);
        check("t5_err_sticky", {31'd0, resp_err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
